prj_gameplay_top: RTL and testbench

- Top level of a single-screen VGA game.
- Generates 1024x768 frame timing (1344x806 total), with one pixel per clock; the simulation clock is 40 MHz.
- Runs a MENU/PLAY state machine driven by a 4-bit key code from the keyboard decoder.
- Renders the menu or the play field as 4-bit RGB with aligned hs/vs.

---
 rtl/vga_pkg.sv | 43 ++++
 rtl/vga_timing.sv | 42 ++++
 rtl/prj_gameplay_top.sv | 127 ++++++++++++
 tb/tb_prj_gameplay_top.sv | 234 +++++++++++++++++++++++
 4 files changed

// File: rtl/vga_pkg.sv
// Shared timing constants, key codes, FSM states and colours for the VGA game.
package vga_pkg;

  localparam logic [10:0] HOR_TOTAL   = 11'd1344;
  localparam logic [10:0] HOR_ACTIVE  = 11'd1024;
  localparam logic [10:0] HSYNC_START = 11'd1048;
  localparam logic [10:0] HSYNC_STOP  = 11'd1184;
  localparam logic [10:0] VER_TOTAL   = 11'd806;
  localparam logic [10:0] VER_ACTIVE  = 11'd768;
  localparam logic [10:0] VSYNC_START = 11'd771;
  localparam logic [10:0] VSYNC_STOP  = 11'd777;

  localparam logic [3:0] key_none  = 4'h0;
  localparam logic [3:0] key_1     = 4'h1;
  localparam logic [3:0] key_2     = 4'h2;
  localparam logic [3:0] key_3     = 4'h3;
  localparam logic [3:0] key_left  = 4'h4;
  localparam logic [3:0] key_right = 4'h5;
  localparam logic [3:0] key_esc   = 4'hF;

  typedef enum logic {MENU, PLAY} state_e;

  typedef struct packed {
    logic [3:0] r;
    logic [3:0] g;
    logic [3:0] b;
  } rgb_t;

  localparam rgb_t C_BLACK  = '{4'h0, 4'h0, 4'h0};
  localparam rgb_t C_WHITE  = '{4'hF, 4'hF, 4'hF};
  localparam rgb_t C_GREY   = '{4'h8, 4'h8, 4'h8};
  localparam rgb_t C_DKBLUE = '{4'h0, 4'h0, 4'h4};
  localparam rgb_t C_YELLOW = '{4'hF, 4'hF, 4'h0};
  localparam rgb_t C_RED    = '{4'hF, 4'h0, 4'h0};
  localparam rgb_t C_GREEN  = '{4'h0, 4'h8, 4'h0};

  // Half-open span test [lo, lo+len) on 11-bit screen coordinates.
  function automatic logic in_span(input logic [10:0] v, input logic [10:0] lo,
                                   input logic [10:0] len);
    return (v >= lo) && (v < lo + len);
  endfunction

endpackage

// File: rtl/vga_timing.sv
// 1024x768 frame counters with combinational sync/blank decode of the current position.
module vga_timing
  import vga_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  output logic [10:0] hcount,
  output logic [10:0] vcount,
  output logic        hsync,
  output logic        vsync,
  output logic        blank
);

  logic [10:0] hcount_q, hcount_d;
  logic [10:0] vcount_q, vcount_d;

  always_comb begin
    hcount_d = hcount_q + 11'd1;
    vcount_d = vcount_q;
    if (hcount_q == HOR_TOTAL - 11'd1) begin
      hcount_d = '0;
      vcount_d = (vcount_q == VER_TOTAL - 11'd1) ? '0 : vcount_q + 11'd1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hcount_q <= '0;
      vcount_q <= '0;
    end else begin
      hcount_q <= hcount_d;
      vcount_q <= vcount_d;
    end
  end

  assign hcount = hcount_q;
  assign vcount = vcount_q;
  assign hsync  = (hcount_q >= HSYNC_START) && (hcount_q < HSYNC_STOP);
  assign vsync  = (vcount_q >= VSYNC_START) && (vcount_q < VSYNC_STOP);
  assign blank  = (hcount_q >= HOR_ACTIVE) || (vcount_q >= VER_ACTIVE);

endmodule

// File: rtl/prj_gameplay_top.sv
// Game top: MENU/PLAY state machine, per-frame player motion and the registered draw stage.
module prj_gameplay_top
  import vga_pkg::*;
#(
  parameter int PLAYER_SIZE = 32,
  parameter int STEP_UNIT   = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] key,
  output logic       vs,
  output logic       hs,
  output logic [3:0] r,
  output logic [3:0] g,
  output logic [3:0] b
);

  localparam logic [10:0]        PSIZE    = 11'(PLAYER_SIZE);
  localparam logic [10:0]        X_START  = 11'd496;
  localparam logic [10:0]        PLAYER_Y = 11'd700;
  localparam logic [10:0]        GROUND_Y = 11'd732;
  localparam logic signed [11:0] X_MAX    = 12'(int'(HOR_ACTIVE) - PLAYER_SIZE);
  localparam logic signed [11:0] STEP     = 12'(STEP_UNIT);

  logic [10:0] hcount, vcount;
  logic        hsync, vsync, blank;

  vga_timing u_timing (
    .clk    (clk),
    .rst    (rst),
    .hcount (hcount),
    .vcount (vcount),
    .hsync  (hsync),
    .vsync  (vsync),
    .blank  (blank)
  );

  logic [3:0]  key_q;
  state_e      state_q, state_d;
  logic [1:0]  level_q, level_d;
  logic [10:0] x_q, x_d;
  logic        hs_q, hs_d, vs_q, vs_d;
  rgb_t        rgb_q, rgb_d;

  logic               frame_tick;
  logic signed [11:0] step_s, x_moved;

  assign frame_tick = (hcount == 11'd0) && (vcount == VER_ACTIVE);

  // Signed 12-bit so a left step from near 0 goes negative instead of wrapping.
  always_comb begin
    step_s  = STEP * $signed({10'd0, level_q});
    x_moved = $signed({1'b0, x_q});
    if (key_q == key_left)       x_moved = x_moved - step_s;
    else if (key_q == key_right) x_moved = x_moved + step_s;
    if (x_moved < 12'sd0)        x_moved = 12'sd0;
    else if (x_moved > X_MAX)    x_moved = X_MAX;
  end

  always_comb begin
    state_d = state_q;
    level_d = level_q;
    x_d     = x_q;
    if (state_q == PLAY && frame_tick) x_d = x_moved[10:0];
    case (state_q)
      MENU: begin
        if (key_q == key_1 || key_q == key_2 || key_q == key_3) begin
          state_d = PLAY;
          level_d = key_q[1:0];
          x_d     = X_START;
        end
      end
      default: ;
    endcase
    if (key_q == key_esc) state_d = MENU;
  end

  // Later assignments win, so each screen is painted back-to-front.
  always_comb begin
    rgb_d = C_BLACK;
    if (state_q == MENU) begin
      rgb_d = C_DKBLUE;
      for (int i = 0; i < 3; i++) begin
        if (in_span(hcount, 11'(162 + 250 * i), 11'd200) && in_span(vcount, 11'd334, 11'd100))
          rgb_d = (level_q == 2'(i + 1)) ? C_WHITE : C_GREY;
      end
    end else begin
      if (vcount >= GROUND_Y) rgb_d = C_GREEN;
      for (int i = 0; i < 3; i++) begin
        if (2'(i) < level_q && in_span(hcount, 11'(16 + 24 * i), 11'd16)
            && in_span(vcount, 11'd16, 11'd16))
          rgb_d = C_RED;
      end
      if (in_span(hcount, x_q, PSIZE) && in_span(vcount, PLAYER_Y, PSIZE)) rgb_d = C_YELLOW;
    end
    if (blank) rgb_d = C_BLACK;
    hs_d = hsync;
    vs_d = vsync;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      key_q   <= key_none;
      state_q <= MENU;
      level_q <= 2'd1;
      x_q     <= X_START;
      hs_q    <= 1'b0;
      vs_q    <= 1'b0;
      rgb_q   <= C_BLACK;
    end else begin
      key_q   <= key;
      state_q <= state_d;
      level_q <= level_d;
      x_q     <= x_d;
      hs_q    <= hs_d;
      vs_q    <= vs_d;
      rgb_q   <= rgb_d;
    end
  end

  assign hs = hs_q;
  assign vs = vs_q;
  assign r  = rgb_q.r;
  assign g  = rgb_q.g;
  assign b  = rgb_q.b;

endmodule

// File: tb/tb_prj_gameplay_top.sv
// Bench for prj_gameplay_top: frame-level model checked every clock plus literal pixel/timing probes.
`timescale 1ns/1ps
module tb_prj_gameplay_top;
  import vga_pkg::*;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic [3:0] key = 4'h0;
  logic       vs, hs;
  logic [3:0] r, g, b;

  prj_gameplay_top dut (
    .clk (clk), .rst (rst), .key (key),
    .vs  (vs),  .hs  (hs),  .r   (r), .g (g), .b (b)
  );

  always #12.5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  // Model: screen position, game state and the one-clock-delayed key.
  int         m_h, m_v, m_lvl, m_x;
  bit         m_play;
  logic [3:0] m_keyq;
  bit         exp_hs, exp_vs;
  logic [11:0] exp_rgb;
  bit         chk_en = 1'b0;
  logic [10:0] jh, jv;

  function automatic logic [11:0] pix(int h, int v);
    if (h >= 1024 || v >= 768) return 12'h000;
    if (!m_play) begin
      for (int i = 0; i < 3; i++)
        if (h >= 162 + 250 * i && h < 362 + 250 * i && v >= 334 && v < 434)
          return (m_lvl == i + 1) ? 12'hFFF : 12'h888;
      return 12'h004;
    end
    if (h >= m_x && h < m_x + 32 && v >= 700 && v < 732) return 12'hFF0;
    for (int i = 0; i < m_lvl; i++)
      if (h >= 16 + 24 * i && h < 32 + 24 * i && v >= 16 && v < 32) return 12'hF00;
    if (v >= 732) return 12'h080;
    return 12'h000;
  endfunction

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_h = 0; m_v = 0; m_play = 0; m_lvl = 1; m_x = 496; m_keyq = 4'h0;
      exp_hs = 0; exp_vs = 0; exp_rgb = 12'h000;
    end else begin
      exp_hs  = (m_h >= 1048 && m_h < 1184);
      exp_vs  = (m_v >= 771 && m_v < 777);
      exp_rgb = pix(m_h, m_v);
      if (m_play && m_h == 0 && m_v == 768) begin
        if (m_keyq == 4'h4)      m_x = (m_x - 4 * m_lvl < 0)   ? 0   : m_x - 4 * m_lvl;
        else if (m_keyq == 4'h5) m_x = (m_x + 4 * m_lvl > 992) ? 992 : m_x + 4 * m_lvl;
      end
      if (m_keyq == 4'hF) m_play = 0;
      else if (!m_play && m_keyq >= 4'h1 && m_keyq <= 4'h3) begin
        m_play = 1; m_lvl = int'(m_keyq); m_x = 496;
      end
      m_keyq = key;
      m_h++;
      if (m_h == 1344) begin
        m_h = 0; m_v++;
        if (m_v == 806) m_v = 0;
      end
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      n_vec++;
      if (hs !== exp_hs || vs !== exp_vs || {r, g, b} !== exp_rgb) begin
        n_err++;
        $display("FAIL model next_pos=(%0d,%0d): got hs=%b vs=%b rgb=%h, want hs=%b vs=%b rgb=%h",
                 m_h, m_v, hs, vs, {r, g, b}, exp_hs, exp_vs, exp_rgb);
      end
    end
  end

  task automatic chk(input string name, input int got, input int want);
    n_vec++;
    if (got !== want) begin
      n_err++;
      $display("FAIL %s: got %0h want %0h", name, got, want);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Move the frame counters (DUT and model) to (h,v); call just after a negedge.
  task automatic jump(input int h, input int v);
    jh = 11'(h);
    jv = 11'(v);
    force dut.u_timing.hcount_q = jh;
    force dut.u_timing.vcount_q = jv;
    #1;
    release dut.u_timing.hcount_q;
    release dut.u_timing.vcount_q;
    m_h = h;
    m_v = v;
  endtask

  task automatic px(input string name, input int h, input int v, input int want);
    @(negedge clk);
    jump(h, v);
    @(negedge clk);
    chk(name, int'({r, g, b}), want);
  endtask

  task automatic frame_step();
    @(negedge clk);
    jump(1340, 767);
    tick(8);
  endtask

  // Count clocks until sig reaches lvl; returns -1 if the bound expires.
  task automatic wait_lvl(input bit use_vs, input bit lvl, input int bound, output int cnt);
    cnt = 0;
    while (((use_vs ? vs : hs) !== lvl) && cnt < bound) begin
      @(negedge clk);
      cnt++;
    end
    if (cnt >= bound) cnt = -1;
  endtask

  initial begin
    int c;
    #1 rst = 1'b1;
    #1;
    chk("reset_hs", int'(hs), 0);
    chk("reset_vs", int'(vs), 0);
    chk("reset_rgb", int'({r, g, b}), 0);
    chk_en = 1'b1;
    tick(3);
    rst = 1'b0;
    tick(100);

    px("menu_lvl1_box", 262, 384, 12'hFFF);
    px("menu_box2_grey", 512, 384, 12'h888);
    px("menu_bg", 10, 10, 12'h004);
    px("menu_box1_left_edge", 161, 384, 12'h004);
    px("menu_box1_corner", 361, 433, 12'hFFF);
    px("menu_box1_below", 300, 434, 12'h004);
    px("blank_h1024", 1024, 384, 12'h000);

    // hsync: jump to h=1040, first high output at h=1048 -> 9 clocks later.
    @(negedge clk); jump(1040, 10);
    wait_lvl(0, 1, 50, c);    chk("hs_rise_delay", c, 9);
    wait_lvl(0, 0, 2000, c);  chk("hs_high_width", c, 136);
    wait_lvl(0, 1, 2000, c);  chk("hs_low_width", c, 1344 - 136);

    // vsync: from (1340,770) the line-771 start is 4 clocks away, output one clock later.
    @(negedge clk); jump(1340, 770);
    wait_lvl(1, 1, 50, c);     chk("vs_rise_delay", c, 5);
    wait_lvl(1, 0, 10000, c);  chk("vs_high_width", c, 6 * 1344);

    @(negedge clk); jump(1340, 805);
    tick(20);

    key = key_esc; tick(4);
    key = key_3;   tick(2);
    chk("state_play", int'(dut.state_q), int'(PLAY));
    chk("level_3", int'(dut.level_q), 3);
    tick(4);
    key = key_1; tick(4);
    chk("digit_ignored_in_play", int'(dut.level_q), 3);
    key = key_none; tick(2);

    px("lvl_sq0", 16, 16, 12'hF00);
    px("lvl_sq1", 40, 16, 12'hF00);
    px("lvl_sq2", 64, 31, 12'hF00);
    px("lvl_gap", 32, 16, 12'h000);
    px("lvl_sq3_absent", 88, 16, 12'h000);
    px("player_tl", 496, 700, 12'hFF0);
    px("player_br", 527, 731, 12'hFF0);
    px("player_right", 528, 700, 12'h000);
    px("ground", 0, 740, 12'h080);

    key = key_right;
    repeat (2) frame_step();
    chk("x_after_2_right", int'(dut.x_q), 520);
    px("player_moved", 520, 700, 12'hFF0);
    px("player_moved_left", 519, 700, 12'h000);
    repeat (45) frame_step();
    chk("x_sat_right", int'(dut.x_q), 992);
    px("player_at_edge", 1023, 731, 12'hFF0);

    key = key_left;
    repeat (90) frame_step();
    chk("x_sat_left", int'(dut.x_q), 0);
    px("player_at_zero", 0, 700, 12'hFF0);

    // Esc lands in key_q on the very clock of the motion update.
    key = key_right;
    @(negedge clk); jump(1340, 767);
    tick(3);
    key = key_esc;
    tick(3);
    chk("esc_to_menu", int'(dut.state_q), int'(MENU));
    chk("esc_keeps_level", int'(dut.level_q), 3);
    chk("esc_blocks_motion", int'(dut.x_q), 0);
    key = key_right;
    frame_step();
    chk("menu_no_motion", int'(dut.x_q), 0);
    key = key_none;
    px("menu_lvl3_box", 762, 384, 12'hFFF);
    px("menu_lvl1_grey", 262, 384, 12'h888);

    // Asynchronous reset mid-frame.
    @(negedge clk); jump(500, 400);
    tick(3);
    #2 rst = 1'b1;
    #1;
    chk("midreset_rgb", int'({r, g, b}), 0);
    chk("midreset_hcount", int'(dut.u_timing.hcount_q), 0);
    chk("midreset_state", int'(dut.state_q), int'(MENU));
    chk("midreset_level", int'(dut.level_q), 1);
    chk("midreset_x", int'(dut.x_q), 496);
    tick(2);
    rst = 1'b0;
    tick(50);
    px("after_reset_lvl1", 262, 384, 12'hFFF);
    tick(5);

    chk_en = 1'b0;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
